// File: rtl/ec_pkg.sv
// rtl/ec_pkg.sv - shared op and state encodings for the bit-serial logic unit
package ec_pkg;
   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOT = 2'b11;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_RUN  = S_RUN,
      ST_DONE = S_DONE
   } state_t;
endpackage

// File: rtl/cl.sv
// rtl/cl.sv - one-bit logic cell: AND / OR / XOR / NOT a, selected by S
module cl
   import ec_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic [1:0] S,
   output logic       y
);
   always_comb begin
      case (S)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         default: y = ~a;
      endcase
   end
endmodule

// File: rtl/bit_serial_lu.sv
// rtl/bit_serial_lu.sv - N-bit logic unit sequencing operand bits LSB-first through cl
// Optional zero flag output enabled by BSLU_ZERO_FLAG_EN.
module bit_serial_lu
   import ec_pkg::*;
#(
   parameter int N = 8,
   localparam int CW = $clog2(N + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [1:0]   op,
   output logic         busy,
   output logic         done,
`ifdef BSLU_ZERO_FLAG_EN
   output logic         zero,
`endif
   output logic [N-1:0] result
);
   state_t        state;
   logic [CW-1:0] count;
   logic [N-1:0]  sa;
   logic [N-1:0]  sb;
   logic [1:0]    sop;
   logic          cell_out;
`ifdef BSLU_ZERO_FLAG_EN
   logic          any_one;
`endif

   cl u_cl (
      .a (sa[0]),
      .b (sb[0]),
      .S (sop),
      .y (cell_out)
   );

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         count  <= '0;
         sa     <= '0;
         sb     <= '0;
         sop    <= OP_AND;
         result <= '0;
`ifdef BSLU_ZERO_FLAG_EN
         any_one <= 1'b0;
         zero    <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  sa     <= a;
                  sb     <= b;
                  sop    <= op;
                  count  <= '0;
                  result <= '0;
                  state  <= ST_RUN;
`ifdef BSLU_ZERO_FLAG_EN
                  any_one <= 1'b0;
                  zero    <= 1'b0;
`endif
               end
            end
            ST_RUN: begin
               // cell output enters at the MSB so the first (LSB) bit lands in bit 0 after N shifts
               result <= {cell_out, result[N-1:1]};
               sa     <= sa >> 1;
               sb     <= sb >> 1;
               count  <= count + CW'(1);
`ifdef BSLU_ZERO_FLAG_EN
               any_one <= any_one | cell_out;
`endif
               if (count == CW'(N - 1)) state <= ST_DONE;
            end
            ST_DONE: begin
`ifdef BSLU_ZERO_FLAG_EN
               zero <= ~any_one;
`endif
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bit_serial_lu.sv
// tb/tb_bit_serial_lu.sv - self-checking bench for bit_serial_lu (N=8), vectors plus random model
module tb_bit_serial_lu;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [1:0]   op;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
`ifdef BSLU_ZERO_FLAG_EN
   logic         zero;
`endif

   int checks = 0;
   int failures = 0;

   bit_serial_lu #(.N(N)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .a      (a),
      .b      (b),
      .op     (op),
      .busy   (busy),
      .done   (done),
`ifdef BSLU_ZERO_FLAG_EN
      .zero   (zero),
`endif
      .result (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [1:0] op;
      logic [7:0] exp;
   } vec_t;

   function automatic logic [7:0] ref_lu(input logic [7:0] x, input logic [7:0] y, input logic [1:0] o);
      case (o)
         2'b00:   return x & y;
         2'b01:   return x | y;
         2'b10:   return x ^ y;
         default: return ~x;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // one start pulse; latency counted in falling edges after the accepting edge
   task automatic run_op(input string name, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [1:0] iop, input logic [7:0] exp, input bit disturb);
      int lat;
      @(negedge clk);
      a = ia; b = ib; op = iop; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (disturb) begin a = ~ia; b = ~ib; op = ~iop; end
      chk({name, "_busy_run"}, busy, 1);
`ifdef BSLU_ZERO_FLAG_EN
      chk({name, "_zero_clr"}, zero, 0);
`endif
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         if (k > 1) @(negedge clk);
         if (done) begin lat = k; break; end
      end
      chk({name, "_latency"}, lat, N + 1);
      chk({name, "_result"}, result, exp);
      @(negedge clk);
`ifdef BSLU_ZERO_FLAG_EN
      chk({name, "_zero"}, zero, (exp == 8'h00));
`endif
      chk({name, "_idle"}, {busy, done}, 0);
      chk({name, "_hold"}, result, exp);
   endtask

   vec_t tbl[6];
   int   pulses[$];
   logic [7:0] ra, rb, rexp;
   logic [1:0] rop;

   initial begin
      tbl[0] = '{8'hCA, 8'h5C, 2'b00, 8'h48};
      tbl[1] = '{8'hCA, 8'h5C, 2'b01, 8'hDE};
      tbl[2] = '{8'hCA, 8'h5C, 2'b10, 8'h96};
      tbl[3] = '{8'hCA, 8'h5C, 2'b11, 8'h35};
      tbl[4] = '{8'h0F, 8'hF0, 2'b10, 8'hFF};
      tbl[5] = '{8'h01, 8'h01, 2'b10, 8'h00};

      reset = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("reset_idle", {busy, done, result}, 0);
`ifdef BSLU_ZERO_FLAG_EN
         chk("reset_zero", zero, 0);
`endif
      end

      for (int i = 0; i < 6; i++) run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp, i[0]);
      run_op("zero_clear", 8'h80, 8'h00, 2'b01, 8'h80, 1'b0);

      // start pulses inside RUN and DONE must be ignored
      @(negedge clk);
      a = 8'hCA; b = 8'h5C; op = 2'b01; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = 8'hFF; b = 8'h00; op = 2'b01;
      for (int k = 1; k <= 10; k++) begin
         if (k > 1) @(negedge clk);
         if (k <= 9) chk($sformatf("ign_busy_k%0d", k), busy, 1);
         chk($sformatf("ign_done_k%0d", k), done, (k == 9));
         start = (k == 3 || k == 9);
      end
      chk("ign_no_restart", busy, 0);
      chk("ign_result", result, 8'hDE);

      // reset mid-operation aborts without a done pulse
      @(negedge clk);
      a = 8'hCA; b = 8'h5C; op = 2'b00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_state", {busy, done, result}, 0);
      begin
         bit seen = 0;
         for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) seen = 1;
         end
         chk("abort_no_done", seen, 0);
      end
      run_op("after_abort", 8'h0F, 8'hF0, 2'b10, 8'hFF, 1'b0);

      // start held high: one op per N+2 cycles
      @(negedge clk);
      a = 8'hAA; b = 8'h55; op = 2'b00; start = 1'b1;
      for (int k = 0; k < 45; k++) begin
         @(negedge clk);
         if (done) begin
            pulses.push_back(k);
            chk("held_result", result, 8'h00);
`ifdef BSLU_ZERO_FLAG_EN
            @(negedge clk);
            k++;
            chk("held_zero", zero, 1);
`endif
         end
      end
      start = 1'b0;
      chk("held_pulse_count", (pulses.size() >= 4), 1);
      for (int i = 1; i < pulses.size(); i++) chk("held_period", pulses[i] - pulses[i-1], N + 2);
      repeat (12) @(negedge clk);

      for (int i = 0; i < 24; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rop = 2'($urandom_range(0, 3));
         rexp = ref_lu(ra, rb, rop);
         run_op($sformatf("rand%0d", i), ra, rb, rop, rexp, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
